// File: rtl/decode_pipe_if.sv
// Decode-to-execute bundle for decode_pipe: D-stage inputs, W-stage writeback, E-stage outputs.
// The master side drives decode/writeback/control; the slave side is the pipeline register.
interface decode_pipe_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 16
);
  logic              validD;
  logic [31:0]       instrD;
  logic [XLEN-1:0]   pcD;
  logic [CTRL_W-1:0] ctrlD;
  logic [XLEN-1:0]   immD;
  logic              memReadD;
  logic              flushE;
  logic              holdE;
  logic              regWriteW;
  logic [4:0]        rdW;
  logic [XLEN-1:0]   resultW;

  logic              stallD;
  logic              validE;
  logic              memReadE;
  logic [CTRL_W-1:0] ctrlE;
  logic [XLEN-1:0]   immE;
  logic [XLEN-1:0]   pcE;
  logic [XLEN-1:0]   r1E;
  logic [XLEN-1:0]   r2E;
  logic [4:0]        rs1E;
  logic [4:0]        rs2E;
  logic [4:0]        rdE;

  modport master (
    output validD, instrD, pcD, ctrlD, immD, memReadD, flushE, holdE,
    output regWriteW, rdW, resultW,
    input  stallD, validE, memReadE, ctrlE, immE, pcE, r1E, r2E, rs1E, rs2E, rdE
  );

  modport slave (
    input  validD, instrD, pcD, ctrlD, immD, memReadD, flushE, holdE,
    input  regWriteW, rdW, resultW,
    output stallD, validE, memReadE, ctrlE, immE, pcE, r1E, r2E, rs1E, rs2E, rdE
  );
endinterface

// File: rtl/decode_pipe.sv
// Decode stage register file, load-use/writeback hazard detection and D->E pipeline register.
// Macro DECODE_WB_BYPASS_EN: when defined, same-cycle writeback is forwarded to the reads.
module decode_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned CTRL_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  decode_pipe_if.slave   bus
);

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   r1;
    logic [XLEN-1:0]   r2;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
  } e_stage_t;

  logic [4:0] rs1, rs2, rd;
  assign rs1 = bus.instrD[19:15];
  assign rs2 = bus.instrD[24:20];
  assign rd  = bus.instrD[11:7];

  logic unused_instr;
  assign unused_instr = ^{bus.instrD[31:25], bus.instrD[14:12], bus.instrD[6:0]};

  // Register file; entry 0 is never written so it stays 0 after reset.
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic            rf_we;

  assign rf_we = bus.regWriteW && (bus.rdW != 5'd0) && (32'(bus.rdW) < NREGS);

  always_comb begin
    rf_d = rf_q;
    if (rf_we) begin
      for (int i = 1; i < NREGS; i++) begin
        if (bus.rdW == 5'(i)) rf_d[i] = bus.resultW;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Out-of-range and x0 indices fall through to the zero default.
  logic [XLEN-1:0] rd1_raw, rd2_raw;
  always_comb begin
    rd1_raw = '0;
    rd2_raw = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs1 == 5'(i)) rd1_raw = rf_q[i];
      if (rs2 == 5'(i)) rd2_raw = rf_q[i];
    end
  end

  logic [XLEN-1:0] r1_val, r2_val;
  logic            wb_hazard;

`ifdef DECODE_WB_BYPASS_EN
  // rf_we already implies rdW is nonzero and in range.
  assign r1_val    = (rf_we && (bus.rdW == rs1)) ? bus.resultW : rd1_raw;
  assign r2_val    = (rf_we && (bus.rdW == rs2)) ? bus.resultW : rd2_raw;
  assign wb_hazard = 1'b0;
`else
  assign r1_val    = rd1_raw;
  assign r2_val    = rd2_raw;
  assign wb_hazard = bus.validD && bus.regWriteW && (bus.rdW != 5'd0) &&
                     ((bus.rdW == rs1) || (bus.rdW == rs2));
`endif

  e_stage_t e_q, e_d;
  logic     load_use;
  logic     stall;

  always_comb begin
    load_use = e_q.valid && e_q.mem_read && (e_q.rd != 5'd0) && bus.validD &&
               ((e_q.rd == rs1) || (e_q.rd == rs2));
    stall    = (load_use || wb_hazard) && !bus.flushE && !rst;

    e_d = e_q;
    if (bus.flushE) begin
      e_d = '0;
    end else if (bus.holdE) begin
      e_d = e_q;
    end else if (stall) begin
      e_d = '0;
    end else begin
      e_d.valid    = bus.validD;
      e_d.mem_read = bus.memReadD && bus.validD;
      e_d.ctrl     = bus.validD ? bus.ctrlD : '0;
      e_d.imm      = bus.immD;
      e_d.pc       = bus.pcD;
      e_d.r1       = r1_val;
      e_d.r2       = r2_val;
      e_d.rs1      = rs1;
      e_d.rs2      = rs2;
      e_d.rd       = rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) e_q <= '0;
    else     e_q <= e_d;
  end

  assign bus.stallD   = stall;
  assign bus.validE   = e_q.valid;
  assign bus.memReadE = e_q.mem_read;
  assign bus.ctrlE    = e_q.ctrl;
  assign bus.immE     = e_q.imm;
  assign bus.pcE      = e_q.pc;
  assign bus.r1E      = e_q.r1;
  assign bus.r2E      = e_q.r2;
  assign bus.rs1E     = e_q.rs1;
  assign bus.rs2E     = e_q.rs2;
  assign bus.rdE      = e_q.rd;

endmodule

// File: tb/tb_decode_pipe.sv
// Randomized bench for decode_pipe against a behavioural pipeline model, plus directed cases.
// A second instance with NREGS=16 covers the reduced register file.
module tb_decode_pipe;

  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_pipe_if #(.XLEN(32), .CTRL_W(16)) bus ();
  decode_pipe_if #(.XLEN(32), .CTRL_W(16)) bus16 ();

  decode_pipe #(.XLEN(32), .NREGS(32), .CTRL_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  decode_pipe #(.XLEN(32), .NREGS(16), .CTRL_W(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  typedef struct {
    bit          valid;
    bit          mem_read;
    logic [15:0] ctrl;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } me_t;

  logic [31:0] m_rf [NREGS];
  me_t         m_e;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic me_t bubble();
    me_t b;
    b = '{valid: 1'b0, mem_read: 1'b0, ctrl: '0, imm: '0, pc: '0, r1: '0, r2: '0,
          rs1: '0, rs2: '0, rd: '0};
    return b;
  endfunction

  // Value a D-stage read of register idx must see this cycle.
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0 || int'(idx) >= NREGS) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (bus.regWriteW && bus.rdW == idx) return bus.resultW;
`endif
    return m_rf[idx];
  endfunction

  function automatic bit m_stall();
    logic [4:0] s1, s2;
    bit lu, wb;
    s1 = bus.instrD[19:15];
    s2 = bus.instrD[24:20];
    lu = m_e.valid && m_e.mem_read && m_e.rd != 0 && bus.validD && (m_e.rd == s1 || m_e.rd == s2);
    wb = 1'b0;
`ifndef DECODE_WB_BYPASS_EN
    wb = bus.validD && bus.regWriteW && bus.rdW != 0 && (bus.rdW == s1 || bus.rdW == s2);
`endif
    return (lu || wb) && !bus.flushE;
  endfunction

  task automatic check_e();
    check("validE",   64'(bus.validE),   64'(m_e.valid));
    check("memReadE", 64'(bus.memReadE), 64'(m_e.mem_read));
    check("ctrlE",    64'(bus.ctrlE),    64'(m_e.ctrl));
    check("immE",     64'(bus.immE),     64'(m_e.imm));
    check("pcE",      64'(bus.pcE),      64'(m_e.pc));
    check("r1E",      64'(bus.r1E),      64'(m_e.r1));
    check("r2E",      64'(bus.r2E),      64'(m_e.r2));
    check("rs1E",     64'(bus.rs1E),     64'(m_e.rs1));
    check("rs2E",     64'(bus.rs2E),     64'(m_e.rs2));
    check("rdE",      64'(bus.rdE),      64'(m_e.rd));
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic tick();
    me_t nx;
    bit  st, wr;
    #1;
    st = m_stall();
    check("stallD", 64'(bus.stallD), 64'(st));
    if (bus.flushE)     nx = bubble();
    else if (bus.holdE) nx = m_e;
    else if (st)        nx = bubble();
    else begin
      nx.valid    = bus.validD;
      nx.mem_read = bus.memReadD && bus.validD;
      nx.ctrl     = bus.validD ? bus.ctrlD : 16'h0;
      nx.imm      = bus.immD;
      nx.pc       = bus.pcD;
      nx.r1       = m_read(bus.instrD[19:15]);
      nx.r2       = m_read(bus.instrD[24:20]);
      nx.rs1      = bus.instrD[19:15];
      nx.rs2      = bus.instrD[24:20];
      nx.rd       = bus.instrD[11:7];
    end
    wr = bus.regWriteW && bus.rdW != 0 && int'(bus.rdW) < NREGS;
    @(posedge clk);
    m_e = nx;
    if (wr) m_rf[bus.rdW] = bus.resultW;
    #1;
    check_e();
  endtask

  function automatic logic [31:0] mk(input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [4:0] d);
    return {7'h00, s2, s1, 3'h0, d, 7'h33};
  endfunction

  task automatic idle_main();
    bus.validD = 0; bus.instrD = '0; bus.pcD = '0; bus.ctrlD = '0; bus.immD = '0;
    bus.memReadD = 0; bus.flushE = 0; bus.holdE = 0;
    bus.regWriteW = 0; bus.rdW = '0; bus.resultW = '0;
  endtask

  task automatic idle_16();
    bus16.validD = 0; bus16.instrD = '0; bus16.pcD = '0; bus16.ctrlD = '0; bus16.immD = '0;
    bus16.memReadD = 0; bus16.flushE = 0; bus16.holdE = 0;
    bus16.regWriteW = 0; bus16.rdW = '0; bus16.resultW = '0;
  endtask

  task automatic rand_inputs();
    logic [4:0] s1, s2, d;
    s1 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    s2 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    d  = 5'($urandom_range(0, 7));
    bus.instrD    = $urandom;
    bus.instrD[19:15] = s1;
    bus.instrD[24:20] = s2;
    bus.instrD[11:7]  = d;
    bus.validD    = $urandom_range(0, 3) != 0;
    bus.pcD       = $urandom;
    bus.ctrlD     = 16'($urandom);
    bus.immD      = $urandom;
    bus.memReadD  = $urandom_range(0, 2) == 0;
    bus.flushE    = $urandom_range(0, 9) == 0;
    bus.holdE     = $urandom_range(0, 5) == 0;
    bus.regWriteW = $urandom_range(0, 1) == 1;
    bus.rdW       = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 7));
    bus.resultW   = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    idle_main();
    idle_16();
    for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
    m_e = bubble();
    #12;
    check("reset_validE", 64'(bus.validE), 64'h0);
    check("reset_stallD", 64'(bus.stallD), 64'h0);
    check("reset_r1E",    64'(bus.r1E),    64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Writeback then a dependent decode one cycle later.
    bus.regWriteW = 1; bus.rdW = 5'd5; bus.resultW = 32'h0000_1234;
    tick();
    idle_main();
    bus.validD = 1; bus.instrD = mk(5'd5, 5'd0, 5'd1); bus.ctrlD = 16'h00A5;
    tick();
    check("wb_then_read_r1E",    64'(bus.r1E),    64'h0000_1234);
    check("wb_then_read_validE", 64'(bus.validE), 64'h1);

    // Same-cycle writeback and read of x7.
    idle_main();
    bus.regWriteW = 1; bus.rdW = 5'd7; bus.resultW = 32'hDEAD_BEEF;
    bus.validD = 1; bus.instrD = mk(5'd0, 5'd7, 5'd2); bus.ctrlD = 16'h0011;
`ifdef DECODE_WB_BYPASS_EN
    #1 check("bypass_stallD", 64'(bus.stallD), 64'h0);
    tick();
    check("bypass_r2E", 64'(bus.r2E), 64'hDEAD_BEEF);
`else
    #1 check("nobypass_stallD", 64'(bus.stallD), 64'h1);
    tick();
    check("nobypass_bubble", 64'(bus.validE), 64'h0);
    bus.regWriteW = 0;
    tick();
    check("nobypass_r2E", 64'(bus.r2E), 64'hDEAD_BEEF);
`endif

    // Load-use: load x3 in E, dependent instruction in D.
    idle_main();
    bus.validD = 1; bus.memReadD = 1; bus.instrD = mk(5'd0, 5'd0, 5'd3); bus.ctrlD = 16'h0F0F;
    tick();
    bus.memReadD = 0; bus.instrD = mk(5'd3, 5'd0, 5'd8); bus.ctrlD = 16'h1234;
    #1 check("loaduse_stallD", 64'(bus.stallD), 64'h1);
    tick();
    check("loaduse_bubble_valid", 64'(bus.validE), 64'h0);
    check("loaduse_bubble_ctrl",  64'(bus.ctrlE),  64'h0);
    #1 check("loaduse_release", 64'(bus.stallD), 64'h0);
    tick();
    check("loaduse_enter_valid", 64'(bus.validE), 64'h1);
    check("loaduse_enter_rs1",   64'(bus.rs1E),   64'h3);

    // Flush overrides a load-use hazard.
    idle_main();
    bus.validD = 1; bus.memReadD = 1; bus.instrD = mk(5'd0, 5'd0, 5'd4);
    tick();
    bus.memReadD = 0; bus.instrD = mk(5'd4, 5'd0, 5'd9); bus.flushE = 1;
    #1 check("flush_stallD", 64'(bus.stallD), 64'h0);
    tick();
    check("flush_validE", 64'(bus.validE), 64'h0);

    // x0 ignores writes; NREGS=16 instance ignores x20.
    idle_main();
    bus.regWriteW = 1; bus.rdW = 5'd0; bus.resultW = 32'hFFFF_FFFF;
    bus16.regWriteW = 1; bus16.rdW = 5'd20; bus16.resultW = 32'h55;
    tick();
    idle_main();
    bus.validD = 1; bus.instrD = mk(5'd0, 5'd0, 5'd1);
    bus16.rdW = 5'd0; bus16.resultW = 32'hFFFF_FFFF;
    tick();
    check("x0_read", 64'(bus.r1E), 64'h0);
    idle_main();
    bus16.rdW = 5'd5; bus16.resultW = 32'h77;
    tick();
    idle_16();
    bus16.validD = 1; bus16.instrD = mk(5'd20, 5'd0, 5'd1);
    tick();
    check("n16_x20_read", 64'(bus16.r1E),    64'h0);
    check("n16_x0_read",  64'(bus16.r2E),    64'h0);
    check("n16_validE",   64'(bus16.validE), 64'h1);
    bus16.instrD = mk(5'd5, 5'd20, 5'd1);
    tick();
    check("n16_x5_read",  64'(bus16.r1E), 64'h77);
    check("n16_x20_again", 64'(bus16.r2E), 64'h0);
    idle_16();

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      tick();
    end

    // Asynchronous reset while E is valid and held.
    idle_main();
    bus.validD = 1; bus.instrD = mk(5'd1, 5'd2, 5'd3); bus.pcD = 32'h100; bus.immD = 32'h8;
    bus.ctrlD = 16'hBEEF;
    tick();
    check("pre_reset_validE", 64'(bus.validE), 64'h1);
    bus.holdE = 1;
    #1 rst = 1'b1;
    #1;
    check("async_validE", 64'(bus.validE), 64'h0);
    check("async_pcE",    64'(bus.pcE),    64'h0);
    check("async_ctrlE",  64'(bus.ctrlE),  64'h0);
    check("async_immE",   64'(bus.immE),   64'h0);
    check("async_rdE",    64'(bus.rdE),    64'h0);
    check("async_stallD", 64'(bus.stallD), 64'h0);
    m_e = bubble();
    for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
    idle_main();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_e();
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
